// File: rtl/regfile_wb_if.sv
// Writeback/issue bus between the pipeline and the register bank.
// Ports: ALU writeback (aluWe/aluWa/aluWd), load return valid/ready (ldValid/ldReady/ldWa/ldWd),
//   load issue (ldIssue/ldIssueRa), flattened register bus (regOut) and busy scoreboard (busy).
interface regfile_wb_if #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int W    = 8
);
  logic               aluWe;
  logic [AW-1:0]      aluWa;
  logic [W-1:0]       aluWd;
  logic               ldValid;
  logic               ldReady;
  logic [AW-1:0]      ldWa;
  logic [W-1:0]       ldWd;
  logic               ldIssue;
  logic [AW-1:0]      ldIssueRa;
  logic [NREG*W-1:0]  regOut;
  logic [NREG-1:0]    busy;

  // Pipeline side: drives writes/issues, observes registers and scoreboard.
  modport master (
    output aluWe, aluWa, aluWd,
    output ldValid, ldWa, ldWd,
    output ldIssue, ldIssueRa,
    input  ldReady, regOut, busy
  );

  // Register bank side.
  modport slave (
    input  aluWe, aluWa, aluWd,
    input  ldValid, ldWa, ldWd,
    input  ldIssue, ldIssueRa,
    output ldReady, regOut, busy
  );
endinterface

// File: rtl/regfile_wb.sv
// 16x8 register bank with ALU and load-return writeback plus per-register load busy scoreboard.
// Latency: a write committed on a clock edge is visible on regOut/busy right after that edge.
// Backpressure: ALU always wins; load return is stalled (ldReady=0) in any cycle with aluWe=1.
// Ports: clk, reset (async, active-high), bus (regfile_wb_if.slave: ALU, load, issue, regOut, busy).
module regfile_wb #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  regfile_wb_if.slave  bus
);

  logic                   ldFire;
  logic [NREG-1:0][W-1:0] regArr;
  logic [NREG-1:0]        busyVec;

  // ALU has fixed priority, so the two sources never commit in the same cycle.
  assign bus.ldReady = !bus.aluWe;
  assign ldFire      = bus.ldValid && !bus.aluWe;

  // Register 0 is hardwired: no storage, writes and issues to it vanish.
  assign regArr[0]  = '0;
  assign busyVec[0] = 1'b0;

  for (genvar n = 1; n < NREG; n++) begin : gReg
    localparam logic [AW-1:0] IDX = AW'(n);

    logic [W-1:0] dataQ;
    logic         busyQ;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dataQ <= '0;
      end else if (bus.aluWe && (bus.aluWa == IDX)) begin
        dataQ <= bus.aluWd;
      end else if (ldFire && (bus.ldWa == IDX)) begin
        dataQ <= bus.ldWd;
      end
    end

    // A fresh issue outranks a same-cycle return: a back-to-back load to the
    // same register must stay outstanding.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        busyQ <= 1'b0;
      end else if (bus.ldIssue && (bus.ldIssueRa == IDX)) begin
        busyQ <= 1'b1;
      end else if (ldFire && (bus.ldWa == IDX)) begin
        busyQ <= 1'b0;
      end
    end

    assign regArr[n]  = dataQ;
    assign busyVec[n] = busyQ;
  end

  assign bus.regOut = regArr;
  assign bus.busy   = busyVec;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: hand-computed expectations, immediate assertions at each check.
// Inputs change 1 ns after a rising edge; results are checked 1 ns after the following edge.
// Ports: none (top-level bench).
module tb_regfile_wb;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errs = 0;
  logic [W-1:0] m [NREG];

  always #5 clk = ~clk;

  regfile_wb_if #(.NREG(NREG), .AW(AW), .W(W)) bus ();

  regfile_wb #(.NREG(NREG), .AW(AW), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rd(input int n);
    return bus.regOut[n*W +: W];
  endfunction

  function automatic logic [NREG*W-1:0] packModel();
    logic [NREG*W-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i*W +: W] = m[i];
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREG; i++) m[i] = '0;
    bus.aluWe = 0; bus.aluWa = 0; bus.aluWd = 0;
    bus.ldValid = 0; bus.ldWa = 0; bus.ldWd = 0;
    bus.ldIssue = 0; bus.ldIssueRa = 0;

    // Reset and idle
    tick(); tick();
    chk("reset_regOut", bus.regOut, 128'h0);
    chk("reset_busy", bus.busy, 16'h0);
    reset = 1'b0;
    tick();
    chk("idle_regOut", bus.regOut, 128'h0);
    chk("idle_ldReady", bus.ldReady, 1'b1);

    // ALU write reg3 = 3C; no write-through before the edge
    bus.aluWe = 1; bus.aluWa = 3; bus.aluWd = 8'h3C;
    #1;
    chk("alu_ldReady_low", bus.ldReady, 1'b0);
    chk("alu_no_writethrough", rd(3), 8'h00);
    tick();
    m[3] = 8'h3C;
    chk("alu_reg3", rd(3), 8'h3C);

    // ALU write to reg0 dropped
    bus.aluWa = 0; bus.aluWd = 8'hFF;
    tick();
    bus.aluWe = 0;
    chk("alu_reg0", rd(0), 8'h00);
    chk("alu_full", bus.regOut, packModel());

    // Issue load to reg9
    bus.ldIssue = 1; bus.ldIssueRa = 9;
    tick();
    bus.ldIssue = 0;
    chk("issue9_busy", bus.busy, 16'h0200);

    // Load return to reg9
    bus.ldValid = 1; bus.ldWa = 9; bus.ldWd = 8'h77;
    #1;
    chk("ld9_ldReady", bus.ldReady, 1'b1);
    tick();
    bus.ldValid = 0;
    m[9] = 8'h77;
    chk("ld9_reg", rd(9), 8'h77);
    chk("ld9_busy", bus.busy, 16'h0000);

    // Collision: ALU reg2 vs load reg4
    bus.aluWe = 1; bus.aluWa = 2; bus.aluWd = 8'h11;
    bus.ldValid = 1; bus.ldWa = 4; bus.ldWd = 8'h22;
    #1;
    chk("coll_ldReady", bus.ldReady, 1'b0);
    tick();
    m[2] = 8'h11;
    chk("coll_reg2", rd(2), 8'h11);
    chk("coll_reg4_held", rd(4), 8'h00);
    bus.aluWe = 0;
    #1;
    chk("coll_ldReady_release", bus.ldReady, 1'b1);
    tick();
    bus.ldValid = 0;
    m[4] = 8'h22;
    chk("coll_reg4", rd(4), 8'h22);

    // Same-cycle issue and return to reg7
    bus.ldIssue = 1; bus.ldIssueRa = 7;
    tick();
    chk("r7_busy_pre", bus.busy, 16'h0080);
    bus.ldValid = 1; bus.ldWa = 7; bus.ldWd = 8'h5A;
    tick();
    bus.ldIssue = 0;
    m[7] = 8'h5A;
    chk("r7_reg", rd(7), 8'h5A);
    chk("r7_busy_kept", bus.busy, 16'h0080);
    bus.ldWd = 8'h5B;
    tick();
    bus.ldValid = 0;
    m[7] = 8'h5B;
    chk("r7_reg2", rd(7), 8'h5B);
    chk("r7_busy_clr", bus.busy, 16'h0000);

    // ALU write to busy reg12, then load return
    bus.ldIssue = 1; bus.ldIssueRa = 12;
    tick();
    bus.ldIssue = 0;
    bus.aluWe = 1; bus.aluWa = 12; bus.aluWd = 8'h01;
    tick();
    bus.aluWe = 0;
    chk("r12_alu", rd(12), 8'h01);
    chk("r12_busy", bus.busy, 16'h1000);
    bus.ldValid = 1; bus.ldWa = 12; bus.ldWd = 8'hEE;
    tick();
    bus.ldValid = 0;
    m[12] = 8'hEE;
    chk("r12_ld", rd(12), 8'hEE);
    chk("r12_busy_clr", bus.busy, 16'h0000);

    // Issue and return to address 0 dropped
    bus.ldIssue = 1; bus.ldIssueRa = 0;
    bus.ldValid = 1; bus.ldWa = 0; bus.ldWd = 8'hAB;
    tick();
    bus.ldIssue = 0; bus.ldValid = 0;
    chk("r0_busy", bus.busy, 16'h0000);
    chk("r0_reg", rd(0), 8'h00);

    // Issue reg1 while returning to non-busy reg15 (tolerated)
    bus.ldIssue = 1; bus.ldIssueRa = 1;
    bus.ldValid = 1; bus.ldWa = 15; bus.ldWd = 8'h99;
    tick();
    bus.ldIssue = 0; bus.ldValid = 0;
    m[15] = 8'h99;
    chk("diff_busy", bus.busy, 16'h0002);
    chk("diff_full", bus.regOut, packModel());

    // Mid-run async reset
    bus.aluWe = 1; bus.aluWa = 5; bus.aluWd = 8'hA5;
    tick();
    bus.aluWe = 0;
    chk("pre_rst_reg5", rd(5), 8'hA5);
    bus.aluWe = 1; bus.aluWa = 8; bus.aluWd = 8'h3F;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_regOut", bus.regOut, 128'h0);
    chk("async_rst_busy", bus.busy, 16'h0);
    tick();
    chk("rst_drop_write", rd(8), 8'h00);
    bus.aluWe = 0;
    reset = 1'b0;
    tick();
    chk("post_rst_regOut", bus.regOut, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 16 x 8-bit general register bank with two write sources: ALU writeback and load-return.
- Drives the flattened 128-bit register bus that the read-select mux downstream slices by register address. Register 0 is hardwired to zero.
- Keeps a per-register busy scoreboard for outstanding loads so issue logic can stall on RAW hazards.
- The ALU has fixed write priority. The load path uses a valid/ready handshake and is back-pressured on collision.

Parameters:
- NREG, 16, number of registers; must equal 2**AW.
- AW, 4, register address width.
- W, 8, register data width; regOut width is NREG*W (128 at defaults).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- aluWe  input  1  ALU writeback enable; always accepted.
- aluWa  input  AW  ALU destination register.
- aluWd  input  W  ALU write data.
- ldValid  input  1  load-return data valid.
- ldReady  output  1  load-return accepted this cycle.
- ldWa  input  AW  load destination register.
- ldWd  input  W  load data.
- ldIssue  input  1  a load to register ldIssueRa has been issued; mark it busy.
- ldIssueRa  input  AW  destination of the issued load.
- regOut  output  NREG*W  flattened registers; register n occupies bits [n*W+W-1 : n*W].
- busy  output  NREG  busy[n]=1 while a load to register n is outstanding.

Behaviour:
- Reset (async, active-high): all registers = 0, busy = 0. Reset asserted mid-operation discards any in-flight write immediately.
- regOut[W-1:0] is constant 0; busy[0] is constant 0. Writes and issues to address 0 are silently dropped.
- **ldReady** is combinational: ldReady = !aluWe. It does not depend on ldValid.
- **ALU write:** when aluWe=1 and aluWa!=0, reg[aluWa] <= aluWd on the rising edge.
- **Load transfer:** occurs when ldValid && ldReady. Then reg[ldWa] <= ldWd (if ldWa!=0) and busy[ldWa] <= 0.
- **Load hold rule:** when ldValid=1 and ldReady=0, the load source holds ldWa/ldWd stable until the transfer cycle; the block stores nothing.
- **Write latency:** new data appears on regOut the cycle after the write edge. There is no write-through to regOut in the write cycle.
- **Issue:** ldIssue=1 sets busy[ldIssueRa] <= 1.
- **Issue and transfer to the same register in the same cycle:** the set wins, so busy stays 1. The data write still occurs; this is a back-to-back load to the same register.
- **Issue and transfer to different registers:** both take effect.
- **ALU write to a busy register:** data is written and busy is unchanged. The pending load later overwrites it, giving WAW in program order by construction.
- **Load transfer to a non-busy register:** data is written and busy stays 0; the protocol error is tolerated, not flagged.
- No internal state machine beyond the register array and busy vector. Exactly one write per register per cycle, because ALU and load never commit in the same cycle.
- Widths are exact: no sign extension or truncation of write data. Addresses use the full AW range 0..NREG-1.

Test Plan:
- **Reset then idle:** regOut=128'h0, busy=16'h0. Assert reset mid-run after writing reg5=8'hA5 -> regOut and busy clear asynchronously, before the next edge.
- **ALU write:** aluWe=1, aluWa=3, aluWd=8'h3C for one cycle -> regOut[31:24]=8'h3C on the following cycle. aluWa=0, aluWd=8'hFF -> regOut[7:0] stays 8'h00.
- **Load issue/return:**
  - ldIssue with ldIssueRa=9 -> busy=16'h0200 next cycle.
  - ldValid=1, ldWa=9, ldWd=8'h77 with aluWe=0 -> ldReady=1; next cycle regOut[79:72]=8'h77 and busy=16'h0000.
- **Collision:**
  - aluWe=1 (aluWa=2, aluWd=8'h11) with ldValid=1 (ldWa=4, ldWd=8'h22) -> ldReady=0; after the edge reg2=8'h11, reg4 unchanged.
  - Next cycle aluWe=0 -> ldReady=1; reg4=8'h22 the cycle after.
- **Same-cycle issue and return to reg7** (busy[7]=1 beforehand, ldWd=8'h5A) -> reg7=8'h5A and busy[7] remains 1.
- **ALU write to busy reg12** (aluWd=8'h01), then load return ldWd=8'hEE -> reg12 reads 8'h01, then 8'hEE; busy[12] is 1 until the return, then 0.
